// File: rtl/gig_eth_tx_pkg.sv
// Shared types and helpers for the GIG_ETH TX path mux.
// FSM encoding is one-hot; grant decoding picks the lowest set bit.
package gig_eth_tx_pkg;

  localparam int MAX_PATHS = 32;

  typedef enum logic [4:0] {
    IDLE  = 5'b00001,
    XFER  = 5'b00010,
    DROP  = 5'b00100,
    DRAIN = 5'b01000,
    GAP   = 5'b10000
  } state_e;

  function automatic int lowest_set_bit(input logic [MAX_PATHS-1:0] vec);
    int idx;
    idx = 0;
    for (int i = MAX_PATHS - 1; i >= 0; i--) begin
      if (vec[i]) idx = i;
    end
    return idx;
  endfunction

  function automatic logic is_multi_hot(input logic [MAX_PATHS-1:0] vec);
    return (vec & (vec - 1'b1)) != '0;
  endfunction

endpackage

// File: rtl/eth_tx_out_reg.sv
// Single-entry registered output stage towards the MAC TX interface.
// The register accepts a new beat whenever it is empty or its beat is being taken.
module eth_tx_out_reg #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ce,
  input  logic              wr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_last,
  output logic              load,
  output logic [DATA_W-1:0] mac_tdata,
  output logic              mac_tvalid,
  output logic              mac_tlast,
  input  logic              mac_tready
);

  assign load = ce & (~mac_tvalid | mac_tready);

  always_ff @(posedge clk) begin
    if (rst) begin
      mac_tdata  <= '0;
      mac_tvalid <= 1'b0;
      mac_tlast  <= 1'b0;
    end else if (load) begin
      mac_tvalid <= wr;
      if (wr) begin
        mac_tdata <= wr_data;
        mac_tlast <= wr_last;
      end
    end
  end

endmodule

// File: rtl/eth_tx_path_mux.sv
// Locks onto the path granted by the TX arbiter and forwards its frame to the MAC,
// enforcing max frame length, a start timeout and a fixed inter-frame gap.
module eth_tx_path_mux
  import gig_eth_tx_pkg::*;
#(
  parameter int PATH_NUM   = 8,
  parameter int DATA_W     = 8,
  parameter int MAX_LEN    = 1518,
  parameter int IFG_CYCLES = 12,
  parameter int START_TMO  = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       ce,
  input  logic [PATH_NUM-1:0]        app_grand,
  output logic [PATH_NUM-1:0]        app_busy,
  input  logic [PATH_NUM*DATA_W-1:0] path_tdata,
  input  logic [PATH_NUM-1:0]        path_tvalid,
  input  logic [PATH_NUM-1:0]        path_tlast,
  output logic [PATH_NUM-1:0]        path_tready,
  output logic [DATA_W-1:0]          mac_tdata,
  output logic                       mac_tvalid,
  output logic                       mac_tlast,
  input  logic                       mac_tready,
  output logic                       err_trunc,
  output logic                       err_tmo,
  output logic                       err_multi
);

  localparam int OW = (PATH_NUM > 1) ? $clog2(PATH_NUM) : 1;
  localparam int LW = $clog2(MAX_LEN + 1);
  localparam int TW = $clog2(START_TMO + 1);
  localparam int GW = $clog2(IFG_CYCLES + 1);
  localparam logic [LW-1:0] LEN_LAST = LW'(MAX_LEN - 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(START_TMO - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(IFG_CYCLES - 1);

  state_e          state_q, state_d;
  logic [OW-1:0]   owner_q, owner_d;
  logic [LW-1:0]   len_q, len_d;
  logic [TW-1:0]   tmo_q, tmo_d;
  logic [GW-1:0]   gap_q, gap_d;

  logic              load;
  logic              wr;
  logic              wr_last;
  logic              own_ready;
  logic              own_acc;
  logic              own_last;
  logic [DATA_W-1:0] own_data;

  assign own_ready = ce & (((state_q == XFER) & load) | (state_q == DROP));
  assign own_acc   = own_ready & path_tvalid[owner_q];
  assign own_last  = path_tlast[owner_q];
  assign own_data  = path_tdata[owner_q*DATA_W +: DATA_W];

  always_comb begin
    path_tready          = '0;
    path_tready[owner_q] = own_ready;
    app_busy             = '0;
    app_busy[owner_q]    = (state_q != IDLE);
  end

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    len_d     = len_q;
    tmo_d     = tmo_q;
    gap_d     = gap_q;
    wr        = 1'b0;
    wr_last   = 1'b0;
    err_trunc = 1'b0;
    err_tmo   = 1'b0;
    err_multi = 1'b0;
    if (ce) begin
      unique case (state_q)
        IDLE: begin
          if (|app_grand) begin
            owner_d   = OW'(lowest_set_bit(MAX_PATHS'(app_grand)));
            err_multi = is_multi_hot(MAX_PATHS'(app_grand));
            len_d     = '0;
            tmo_d     = '0;
            state_d   = XFER;
          end
        end
        XFER: begin
          if (own_acc) begin
            wr    = 1'b1;
            len_d = len_q + 1'b1;
            if (own_last) begin
              wr_last = 1'b1;
              state_d = DRAIN;
            end else if (len_q == LEN_LAST) begin
              // Close the frame on the MAC side; the rest of the source frame is dropped.
              wr_last   = 1'b1;
              err_trunc = 1'b1;
              state_d   = DROP;
            end
          end else if (len_q == '0) begin
            if (tmo_q == TMO_LAST) begin
              err_tmo = 1'b1;
              gap_d   = '0;
              state_d = GAP;
            end else begin
              tmo_d = tmo_q + 1'b1;
            end
          end
        end
        DROP: begin
          if (own_acc && own_last) state_d = DRAIN;
        end
        DRAIN: begin
          if (load) begin
            gap_d   = '0;
            state_d = GAP;
          end
        end
        GAP: begin
          if (gap_q == GAP_LAST) state_d = IDLE;
          else gap_d = gap_q + 1'b1;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      owner_q <= '0;
      len_q   <= '0;
      tmo_q   <= '0;
      gap_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      len_q   <= len_d;
      tmo_q   <= tmo_d;
      gap_q   <= gap_d;
    end
  end

  eth_tx_out_reg #(
    .DATA_W(DATA_W)
  ) u_out_reg (
    .clk       (clk),
    .rst       (rst),
    .ce        (ce),
    .wr        (wr),
    .wr_data   (own_data),
    .wr_last   (wr_last),
    .load      (load),
    .mac_tdata (mac_tdata),
    .mac_tvalid(mac_tvalid),
    .mac_tlast (mac_tlast),
    .mac_tready(mac_tready)
  );

endmodule

// File: tb/tb_eth_tx_path_mux.sv
// Directed bench for eth_tx_path_mux: frame forwarding, stalls, truncation,
// start timeout, multi-hot grants and mid-frame reset.
module tb_eth_tx_path_mux;

  localparam int PN = 8;
  localparam int DW = 8;

  logic               clk = 1'b0;
  logic               rst;
  logic               ce;
  logic [PN-1:0]      app_grand;
  logic [PN-1:0]      app_busy;
  logic [PN*DW-1:0]   path_tdata;
  logic [PN-1:0]      path_tvalid;
  logic [PN-1:0]      path_tlast;
  logic [PN-1:0]      path_tready;
  logic [DW-1:0]      mac_tdata;
  logic               mac_tvalid;
  logic               mac_tlast;
  logic               mac_tready;
  logic               err_trunc;
  logic               err_tmo;
  logic               err_multi;

  always #5 clk = ~clk;

  eth_tx_path_mux dut (
    .clk        (clk),
    .rst        (rst),
    .ce         (ce),
    .app_grand  (app_grand),
    .app_busy   (app_busy),
    .path_tdata (path_tdata),
    .path_tvalid(path_tvalid),
    .path_tlast (path_tlast),
    .path_tready(path_tready),
    .mac_tdata  (mac_tdata),
    .mac_tvalid (mac_tvalid),
    .mac_tlast  (mac_tlast),
    .mac_tready (mac_tready),
    .err_trunc  (err_trunc),
    .err_tmo    (err_tmo),
    .err_multi  (err_multi)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Source model state
  logic src_en;
  int   src_path, src_n, src_idx, src_base;
  logic src_acc;
  logic rdy_toggle;

  // Monitor state
  int         cyc = 0;
  logic [8:0] mac_q[$];
  int         last_mac_cyc, last_acc_cyc, tmo_cyc, busy_low_cyc;
  int         n_trunc, n_tmo, n_multi;
  logic [PN-1:0] busy_s, tready_seen;
  logic       mac_tvalid_s;
  logic       hold_pend;
  logic [9:0] held;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive_src();
    path_tvalid = '0;
    path_tlast  = '0;
    path_tdata  = '0;
    if (src_en && src_idx < src_n) begin
      path_tvalid[src_path]          = 1'b1;
      path_tlast[src_path]           = (src_idx == src_n - 1);
      path_tdata[src_path*DW +: DW]  = DW'((src_base + src_idx) & 255);
    end
  endtask

  // One clock: sample at negedge, then drive new inputs 1 time unit after posedge.
  task automatic tick();
    @(negedge clk);
    cyc++;
    if (hold_pend) chk("stable", {mac_tvalid, mac_tlast, mac_tdata}, held);
    hold_pend = mac_tvalid & ~mac_tready;
    held      = {mac_tvalid, mac_tlast, mac_tdata};
    if (mac_tvalid && mac_tready) begin
      mac_q.push_back({mac_tlast, mac_tdata});
      last_mac_cyc = cyc;
    end
    src_acc = src_en && path_tvalid[src_path] && path_tready[src_path];
    if (src_acc) last_acc_cyc = cyc;
    if (err_tmo && n_tmo == 0) tmo_cyc = cyc;
    n_trunc      += int'(err_trunc);
    n_tmo        += int'(err_tmo);
    n_multi      += int'(err_multi);
    busy_s        = app_busy;
    mac_tvalid_s  = mac_tvalid;
    tready_seen  |= path_tready;
    @(posedge clk);
    #1;
    if (src_acc) src_idx++;
    drive_src();
    mac_tready = rdy_toggle ? ~mac_tready : 1'b1;
  endtask

  task automatic start_test(input int path, input int n, input int base, input logic en);
    mac_q.delete();
    n_trunc = 0; n_tmo = 0; n_multi = 0;
    tready_seen = '0;
    src_path = path; src_n = n; src_base = base; src_idx = 0; src_en = en;
    drive_src();
  endtask

  task automatic grant(input logic [PN-1:0] g, input logic [PN-1:0] exp_busy);
    app_grand = g;
    tick();
    chk("busy_at_grant", busy_s, '0);
    app_grand = '0;
    tick();
    chk("busy_after_grant", busy_s, exp_busy);
  endtask

  task automatic wait_busy_low(input int lim);
    logic done;
    done = 1'b0;
    for (int i = 0; i < lim && !done; i++) begin
      tick();
      if (busy_s == '0) begin
        done = 1'b1;
        busy_low_cyc = cyc;
      end
    end
    if (!done) chk("busy_drop_timeout", 32'd0, 32'd1);
  endtask

  task automatic check_frame(input int nm, input int base, input logic want_last);
    chk("beats", mac_q.size(), nm);
    for (int i = 0; i < mac_q.size(); i++) begin
      chk("data", mac_q[i][7:0], (base + i) & 255);
      chk("last", mac_q[i][8], want_last && (i == nm - 1));
    end
  endtask

  initial begin
    rst = 1'b1; ce = 1'b1; app_grand = '0; mac_tready = 1'b1; rdy_toggle = 1'b0;
    hold_pend = 1'b0; held = '0; src_acc = 1'b0;
    start_test(0, 0, 0, 1'b0);
    tick(); tick();
    rst = 1'b0;
    chk("rst_busy", app_busy, '0);
    chk("rst_tready", path_tready, '0);
    chk("rst_mac", {mac_tvalid, mac_tlast, mac_tdata}, '0);
    chk("rst_err", {err_trunc, err_tmo, err_multi}, '0);

    // Grant while ce is low is ignored
    ce = 1'b0; app_grand = 8'h04;
    tick();
    ce = 1'b1; app_grand = '0;
    tick();
    chk("ce_low_grant", busy_s, '0);

    // 1: 60-beat frame on path 2
    start_test(2, 60, 8'h10, 1'b1);
    grant(8'h04, 8'h04);
    wait_busy_low(400);
    check_frame(60, 8'h10, 1'b1);
    chk("t1_gap", busy_low_cyc - last_mac_cyc, 13);

    // 2: same frame with a toggling MAC ready
    tick();
    rdy_toggle = 1'b1;
    start_test(2, 60, 8'h40, 1'b1);
    grant(8'h04, 8'h04);
    wait_busy_low(600);
    rdy_toggle = 1'b0;
    check_frame(60, 8'h40, 1'b1);
    chk("t2_gap", busy_low_cyc - last_mac_cyc, 13);

    // 3: oversize frame on path 0
    tick();
    start_test(0, 1600, 0, 1'b1);
    grant(8'h01, 8'h01);
    wait_busy_low(2500);
    check_frame(1518, 0, 1'b1);
    chk("t3_trunc", n_trunc, 1);
    chk("t3_consumed", src_idx, 1600);
    chk("t3_gap", busy_low_cyc - last_acc_cyc, 14);

    // 4: start timeout on path 0
    tick();
    start_test(0, 0, 0, 1'b0);
    app_grand = 8'h01;
    tick();
    begin
      int gcyc;
      gcyc = cyc;
      app_grand = '0;
      wait_busy_low(300);
      chk("t4_tmo_cnt", n_tmo, 1);
      chk("t4_tmo_cyc", tmo_cyc - gcyc, 64);
      chk("t4_gap", busy_low_cyc - tmo_cyc, 13);
      chk("t4_beats", mac_q.size(), 0);
    end

    // 5: multi-hot grant; path 3 offers data but must never see ready
    tick();
    start_test(3, 4, 0, 1'b1);
    grant(8'h0A, 8'h02);
    chk("t5_multi", n_multi, 1);
    wait_busy_low(300);
    chk("t5_p3_ready", tready_seen[3], 1'b0);
    chk("t5_beats", mac_q.size(), 0);
    chk("t5_tmo", n_tmo, 1);

    // 6: reset after beat 20, then a clean frame
    tick();
    start_test(5, 40, 8'h80, 1'b1);
    grant(8'h20, 8'h20);
    for (int i = 0; i < 200 && src_idx < 20; i++) tick();
    chk("t6_beat20", src_idx, 20);
    rst = 1'b1; src_en = 1'b0; drive_src();
    tick();
    rst = 1'b0;
    tick();
    chk("t6_rst_valid", mac_tvalid_s, 1'b0);
    chk("t6_rst_busy", busy_s, '0);
    begin
      int n_last;
      n_last = 0;
      foreach (mac_q[i]) n_last += int'(mac_q[i][8]);
      chk("t6_no_last", n_last, 0);
    end
    start_test(5, 10, 8'hF8, 1'b1);
    grant(8'h20, 8'h20);
    wait_busy_low(200);
    check_frame(10, 8'hF8, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
